// File: rtl/instruction_fetch_unit.sv
// Decoupled instruction fetch: sequential word fetch from a byte-wide memory into a
// small prefetch FIFO toward decode, with redirect flush and fault-then-halt on bad addresses.
module instruction_fetch_unit #(
    parameter int          IMEM_BYTES = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         i_mem [IMEM_BYTES],
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_addr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_instruction,
    output logic [31:0]                        out_pc,
    output logic [31:0]                        out_pc_plus4,
    output logic                               out_fault,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int          AW        = $clog2(IMEM_BYTES);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    function automatic logic [31:0] assemble_word(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        return BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    logic [31:0]   r_fetch_pc;
    logic          r_halted;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic          r_fifo_fault [FIFO_DEPTH];

    logic          w_fault;
    logic [AW-1:0] w_base;
    logic [31:0]   w_word;
    logic          w_pop;
    logic          w_push;

    // A faulting address never reaches the memory index; base 0 is always in range.
    assign w_fault = (r_fetch_pc[1:0] != 2'b00) || (r_fetch_pc > LAST_WORD);
    assign w_base  = w_fault ? '0 : r_fetch_pc[AW-1:0];
    assign w_word  = w_fault ? 32'h0 :
                     assemble_word(i_mem[w_base], i_mem[w_base + AW'(1)],
                                   i_mem[w_base + AW'(2)], i_mem[w_base + AW'(3)]);

    assign w_pop  = (r_count != '0) && out_ready;
    assign w_push = !redirect_valid && !r_halted && ((r_count < DEPTH_C) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_halted   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_addr;
            r_halted   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
                if (w_fault) begin
                    r_halted <= 1'b1;
                end else begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload carries no reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wptr] <= w_word;
            r_fifo_pc[r_wptr]    <= r_fetch_pc;
            r_fifo_fault[r_wptr] <= w_fault;
        end
    end

    assign out_valid       = (r_count != '0);
    assign fifo_count      = r_count;
    assign out_instruction = out_valid ? r_fifo_instr[r_rptr] : 32'h0;
    assign out_pc          = out_valid ? r_fifo_pc[r_rptr] : 32'h0;
    assign out_pc_plus4    = out_valid ? (r_fifo_pc[r_rptr] + 32'd4) : 32'h0;
    assign out_fault       = out_valid ? r_fifo_fault[r_rptr] : 1'b0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: big- and little-endian instances share stimulus and are
// checked every cycle against a queue-based fetch model, plus hand-computed literal points.
module tb_instruction_fetch_unit;

    localparam int MEMB  = 256;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem [MEMB];
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        out_ready;

    logic        be_valid, le_valid, be_fault, le_fault;
    logic [31:0] be_instr, le_instr, be_pc, le_pc, be_pc4, le_pc4;
    logic [2:0]  be_cnt, le_cnt;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(.IMEM_BYTES(MEMB), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset(reset), .i_mem(mem), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .out_valid(be_valid), .out_ready(out_ready),
        .out_instruction(be_instr), .out_pc(be_pc), .out_pc_plus4(be_pc4),
        .out_fault(be_fault), .fifo_count(be_cnt));

    instruction_fetch_unit #(.IMEM_BYTES(MEMB), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .i_mem(mem), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .out_valid(le_valid), .out_ready(out_ready),
        .out_instruction(le_instr), .out_pc(le_pc), .out_pc_plus4(le_pc4),
        .out_fault(le_fault), .fifo_count(le_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] be;
        logic [31:0] le;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_halted = 1'b0;

    task automatic model_step();
        bit   pop, push, bad;
        ent_t e;
        if (reset) begin
            q.delete();
            m_pc = 32'h0;
            m_halted = 1'b0;
            return;
        end
        pop = (q.size() > 0) && out_ready;
        if (redirect_valid) begin
            q.delete();
            m_pc = redirect_addr;
            m_halted = 1'b0;
            return;
        end
        push = !m_halted && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
            bad = (m_pc % 4 != 0) || (longint'(m_pc) + 4 > longint'(MEMB));
            e.pc = m_pc;
            e.fault = bad;
            if (bad) begin
                e.be = 32'h0;
                e.le = 32'h0;
                m_halted = 1'b1;
            end else begin
                e.be = {mem[m_pc], mem[m_pc+1], mem[m_pc+2], mem[m_pc+3]};
                e.le = {mem[m_pc+3], mem[m_pc+2], mem[m_pc+1], mem[m_pc]};
                m_pc = m_pc + 32'd4;
            end
            q.push_back(e);
        end
    endtask

    task automatic check_dut(input string tag, input logic v, input logic [2:0] c,
                             input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic f, input bit little);
        chk({tag, ".valid"}, 32'(v), 32'(q.size() != 0));
        chk({tag, ".count"}, 32'(c), 32'(q.size()));
        if (q.size() != 0) begin
            chk({tag, ".instr"}, ins, little ? q[0].le : q[0].be);
            chk({tag, ".pc"}, pc, q[0].pc);
            chk({tag, ".pc4"}, pc4, q[0].pc + 32'd4);
            chk({tag, ".fault"}, 32'(f), 32'(q[0].fault));
        end else begin
            chk({tag, ".instr_empty"}, ins, 32'h0);
            chk({tag, ".pc_empty"}, pc, 32'h0);
            chk({tag, ".pc4_empty"}, pc4, 32'h0);
            chk({tag, ".fault_empty"}, 32'(f), 32'h0);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check_dut("be", be_valid, be_cnt, be_instr, be_pc, be_pc4, be_fault, 1'b0);
            check_dut("le", le_valid, le_cnt, le_instr, le_pc, le_pc4, le_fault, 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < MEMB; i++) mem[i] = 8'(i * 17);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = 32'h0;
        out_ready = 1'b1;
        step(2);
        chk("reset_valid", 32'(be_valid), 32'h0);
        chk("reset_count", 32'(be_cnt), 32'h0);

        // reset release, streaming
        reset = 1'b0;
        step(1);
        chk("first_be_instr", be_instr, 32'h00112233);
        chk("first_le_instr", le_instr, 32'h33221100);
        chk("first_pc", be_pc, 32'h0);
        chk("first_pc4", be_pc4, 32'h4);
        step(1);
        chk("second_instr", be_instr, 32'h44556677);
        chk("second_pc", be_pc, 32'h4);

        // backpressure from a fresh reset
        reset = 1'b1;
        out_ready = 1'b0;
        step(1);
        reset = 1'b0;
        step(6);
        chk("bp_full_count", 32'(be_cnt), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_pc", be_pc, 32'(4 * k));
            step(1);
        end

        // redirect to 0x40 while three entries are queued
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        step(3);
        chk("pre_redirect_count", 32'(be_cnt), 32'd3);
        redirect_valid = 1'b1;
        redirect_addr = 32'h40;
        out_ready = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_bubble_valid", 32'(be_valid), 32'h0);
        chk("redir_bubble_count", 32'(be_cnt), 32'h0);
        step(1);
        chk("redir_pc", be_pc, 32'h40);
        chk("redir_be_instr", be_instr, 32'h40516273);
        chk("redir_le_instr", le_instr, 32'h73625140);

        // misaligned redirect
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 32'h42;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("mis_fault", 32'(be_fault), 32'h1);
        chk("mis_instr", be_instr, 32'h0);
        chk("mis_pc", be_pc, 32'h42);
        step(10);
        chk("mis_halt_count", 32'(be_cnt), 32'd1);
        redirect_valid = 1'b1;
        redirect_addr = 32'h0;
        out_ready = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("resume_pc", be_pc, 32'h0);
        chk("resume_instr", be_instr, 32'h00112233);
        chk("resume_fault", 32'(be_fault), 32'h0);

        // out-of-range at the top of memory
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 32'hF8;
        step(1);
        redirect_valid = 1'b0;
        step(5);
        chk("oor_count", 32'(be_cnt), 32'd3);
        out_ready = 1'b1;
        chk("oor_f8_pc", be_pc, 32'hF8);
        chk("oor_f8_instr", be_instr, 32'h78899AAB);
        chk("oor_f8_fault", 32'(be_fault), 32'h0);
        step(1);
        chk("oor_fc_pc", be_pc, 32'hFC);
        chk("oor_fc_instr", be_instr, 32'hBCCDDEEF);
        out_ready = 1'b0;
        step(2);
        chk("oor_halted_count", 32'(be_cnt), 32'd2);

        // reset while halted with entries queued
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(be_valid), 32'h0);
        chk("async_reset_count", 32'(be_cnt), 32'h0);
        step(1);
        reset = 1'b0;
        out_ready = 1'b1;
        step(1);
        chk("post_reset_pc", be_pc, 32'h0);
        chk("post_reset_instr", be_instr, 32'h00112233);
        step(2);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'hFC;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("oor_fc_head", be_pc, 32'hFC);
        step(1);
        chk("oor_100_pc", be_pc, 32'h100);
        chk("oor_100_fault", 32'(be_fault), 32'h1);
        step(3);
        chk("oor_drained", 32'(be_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
